// File: rtl/softmax_pass_sequencer.sv
// Address and strobe sequencer for the three softmax passes (MAX, EXP, NORM) over the vector buffer.
// One run per accepted start; a PIPE_LAT-deep delay line turns EXP/NORM reads into write-backs.
module softmax_pass_sequencer #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] vec_len_i,
  input  logic              stall_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        phase_o,
  output logic              acc_clr_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              last_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o
);

  localparam int unsigned      LAT_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(PIPE_LAT - 1);
  localparam int unsigned      DL_LAST  = PIPE_LAT - 1;

  localparam logic [1:0] PH_NONE = 2'd0;
  localparam logic [1:0] PH_MAX  = 2'd1;
  localparam logic [1:0] PH_NORM = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic              en;
    logic [1:0]        ph;
    logic [ADDR_W-1:0] addr;
  } dl_ent_t;

  localparam int unsigned DL_W = PIPE_LAT * $bits(dl_ent_t);

  state_e            state_q, state_d;
  logic [1:0]        pass_q, pass_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] len_m1_q, len_m1_d;
  logic [LAT_W-1:0]  dcnt_q, dcnt_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        phase_q, phase_d;
  logic              acc_clr_q, acc_clr_d;
  logic              rd_en_q, rd_en_d;
  logic              last_q, last_d;

  dl_ent_t [PIPE_LAT-1:0] dl_q, dl_d;
  dl_ent_t                dl_in;
  logic                   frz;

  // Stall only freezes the sequencer while a phase is in flight.
  assign frz = stall_i && ((state_q == S_ISSUE) || (state_q == S_DRAIN));

  // Next-state and registered-output decode.
  always_comb begin
    state_d  = state_q;
    pass_d   = pass_q;
    addr_d   = addr_q;
    len_m1_d = len_m1_q;
    dcnt_d   = dcnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_ISSUE;
          pass_d   = PH_MAX;
          addr_d   = '0;
          // len 0 wraps to DEPTH-1, i.e. a full-depth run
          len_m1_d = vec_len_i - ADDR_W'(1);
        end
      end
      S_ISSUE: begin
        if (!frz) begin
          if (addr_q == len_m1_q) begin
            state_d = S_DRAIN;
            dcnt_d  = '0;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!frz) begin
          if (dcnt_q == LAT_LAST) begin
            if (pass_q == PH_NORM) begin
              state_d = S_DONE;
            end else begin
              state_d = S_ISSUE;
              pass_d  = pass_q + 2'd1;
              addr_d  = '0;
            end
          end else begin
            dcnt_d = dcnt_q + LAT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    phase_d   = ((state_d == S_ISSUE) || (state_d == S_DRAIN)) ? pass_d : PH_NONE;
    rd_en_d   = (state_d == S_ISSUE);
    acc_clr_d = rd_en_d && (addr_d == '0);
    last_d    = rd_en_d && (addr_d == len_m1_d);
  end

  // Read-to-write delay line; holds its contents across stalled cycles.
  always_comb begin
    dl_in.en   = rd_en_q;
    dl_in.ph   = pass_q;
    dl_in.addr = addr_q;
    dl_d       = dl_q;
    if (!frz) begin
      dl_d = DL_W'({dl_q, dl_in});
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      pass_q    <= PH_NONE;
      addr_q    <= '0;
      len_m1_q  <= '0;
      dcnt_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      phase_q   <= PH_NONE;
      acc_clr_q <= 1'b0;
      rd_en_q   <= 1'b0;
      last_q    <= 1'b0;
      dl_q      <= '0;
    end else begin
      state_q   <= state_d;
      pass_q    <= pass_d;
      addr_q    <= addr_d;
      len_m1_q  <= len_m1_d;
      dcnt_q    <= dcnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      phase_q   <= phase_d;
      acc_clr_q <= acc_clr_d;
      rd_en_q   <= rd_en_d;
      last_q    <= last_d;
      dl_q      <= dl_d;
    end
  end

  // Stall suppresses strobes within the same cycle; the line is empty outside ISSUE/DRAIN.
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign phase_o   = phase_q;
  assign rd_addr_o = addr_q;
  assign rd_en_o   = rd_en_q & ~stall_i;
  assign acc_clr_o = acc_clr_q & ~stall_i;
  assign last_o    = last_q & ~stall_i;
  assign wr_en_o   = dl_q[DL_LAST].en & dl_q[DL_LAST].ph[1] & ~stall_i;
  assign wr_addr_o = dl_q[DL_LAST].addr;

endmodule

// File: tb/tb_softmax_pass_sequencer.sv
// Directed bench for softmax_pass_sequencer: timing of all three passes, stall, ignored start,
// mid-run reset and back-to-back runs with start held high.
module tb_softmax_pass_sequencer;

  localparam int unsigned AW = 10;
  localparam int          P  = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [AW-1:0] vec_len_i;
  logic          stall_i;
  logic          busy_o, done_o, acc_clr_o, rd_en_o, last_o, wr_en_o;
  logic [1:0]    phase_o;
  logic [AW-1:0] rd_addr_o, wr_addr_o;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  softmax_pass_sequencer #(.ADDR_W(AW), .PIPE_LAT(P)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .vec_len_i (vec_len_i),
    .stall_i   (stall_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .phase_o   (phase_o),
    .acc_clr_o (acc_clr_o),
    .rd_en_o   (rd_en_o),
    .rd_addr_o (rd_addr_o),
    .last_o    (last_o),
    .wr_en_o   (wr_en_o),
    .wr_addr_o (wr_addr_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".busy"},  32'(busy_o),    32'd0);
    chk({tag, ".done"},  32'(done_o),    32'd0);
    chk({tag, ".phase"}, 32'(phase_o),   32'd0);
    chk({tag, ".rd_en"}, 32'(rd_en_o),   32'd0);
    chk({tag, ".wr_en"}, 32'(wr_en_o),   32'd0);
    chk({tag, ".clr"},   32'(acc_clr_o), 32'd0);
    chk({tag, ".last"},  32'(last_o),    32'd0);
  endtask

  task automatic kick(input logic [AW-1:0] len);
    vec_len_i = len;
    start_i   = 1'b1;
    step();
    start_i   = 1'b0;
  endtask

  // Entered in cycle 1 of a run; checks every cycle through done, then the following idle cycle.
  task automatic run_seq(input int len, input int stall_v, input int stall_n, input int poke_v,
                         output int done_rel);
    int base, v, sc, vend, guard, p, k;
    int ex_done, ex_phase, ex_rd, ex_last, ex_clr, ex_wr;
    bit stl;
    base     = cyc - 1;
    v        = 1;
    sc       = 0;
    guard    = 0;
    done_rel = -1;
    vend     = 3 * (len + P) + 1;
    while (v <= vend && guard < 20000) begin
      stl     = (v == stall_v) && (sc < stall_n);
      stall_i = stl;
      if (poke_v > 0) begin
        start_i = (v == poke_v);
        if (v == poke_v) vec_len_i = 10'd7;
      end
      #1;
      p = (v - 1) / (len + P);
      k = (v - 1) % (len + P);
      if (v == vend) begin
        ex_done = 1; ex_phase = 0; ex_rd = 0; ex_last = 0; ex_clr = 0; ex_wr = 0;
      end else begin
        ex_done  = 0;
        ex_phase = p + 1;
        ex_rd    = (k < len) ? 1 : 0;
        ex_last  = (k == len - 1) ? 1 : 0;
        ex_clr   = (k == 0) ? 1 : 0;
        ex_wr    = (p > 0 && k >= P) ? 1 : 0;
      end
      if (ex_rd == 1)
        chk("rd_addr", 32'(rd_addr_o), 32'(k));
      if (ex_wr == 1)
        chk("wr_addr", 32'(wr_addr_o), 32'(k - P));
      if (stl) begin
        ex_rd = 0; ex_last = 0; ex_clr = 0; ex_wr = 0;
      end
      chk("busy",    32'(busy_o),    32'd1);
      chk("done",    32'(done_o),    32'(ex_done));
      chk("phase",   32'(phase_o),   32'(ex_phase));
      chk("rd_en",   32'(rd_en_o),   32'(ex_rd));
      chk("last",    32'(last_o),    32'(ex_last));
      chk("acc_clr", 32'(acc_clr_o), 32'(ex_clr));
      chk("wr_en",   32'(wr_en_o),   32'(ex_wr));
      if (ex_done == 1) done_rel = cyc - base;
      if (stl) sc++;
      else     v++;
      step();
      guard++;
    end
    stall_i = 1'b0;
    if (poke_v > 0) start_i = 1'b0;
    chk("run_complete", 32'(v), 32'(vend + 1));
    #1;
    chk("post.busy",  32'(busy_o),  32'd0);
    chk("post.done",  32'(done_o),  32'd0);
    chk("post.rd_en", 32'(rd_en_o), 32'd0);
    chk("post.wr_en", 32'(wr_en_o), 32'd0);
  endtask

  initial begin
    int d, e1, e2, e3;
    bit found;
    rst_ni    = 1'b0;
    start_i   = 1'b0;
    vec_len_i = '0;
    stall_i   = 1'b0;
    step();
    step();
    chk_quiet("reset");
    chk("reset.rd_addr", 32'(rd_addr_o), 32'd0);
    chk("reset.wr_addr", 32'(wr_addr_o), 32'd0);
    rst_ni = 1'b1;
    step();
    chk_quiet("idle");

    // 1: len 4, unstalled; done at t22
    kick(10'd4);
    vec_len_i = 10'd9;
    run_seq(4, 0, 0, 0, d);
    chk("t1.done_cycle", 32'(d), 32'd22);

    // 2: len 0 means 1024 per phase
    kick(10'd0);
    run_seq(1024, 0, 0, 0, d);
    chk("t2.done_cycle", 32'(d), 32'd3082);

    // 3: 5-cycle stall while EXP reads address 2
    kick(10'd4);
    run_seq(4, 10, 5, 0, d);
    chk("t3.done_cycle", 32'(d), 32'd27);

    // 4: start pulse and vec_len change during EXP are ignored
    kick(10'd4);
    run_seq(4, 0, 0, 9, d);
    chk("t4.done_cycle", 32'(d), 32'd22);

    // 5: reset during NORM after wr_addr 1, with start asserted alongside
    kick(10'd4);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      #1;
      if (phase_o == 2'd3 && wr_en_o && wr_addr_o == 10'd1) found = 1'b1;
      else step();
    end
    chk("t5.found_wr1", 32'(found), 32'd1);
    rst_ni  = 1'b0;
    start_i = 1'b1;
    step();
    chk_quiet("t5.after_rst");
    rst_ni  = 1'b1;
    start_i = 1'b0;
    step();
    chk_quiet("t5.released");
    step();
    chk_quiet("t5.quiet");
    kick(10'd4);
    run_seq(4, 0, 0, 0, d);
    chk("t5.done_cycle", 32'(d), 32'd22);

    // 6: len 1 with start held high repeats every 14 cycles
    vec_len_i = 10'd1;
    start_i   = 1'b1;
    step();
    e1 = cyc;
    run_seq(1, 0, 0, 0, d);
    chk("t6.done1", 32'(d), 32'd13);
    step();
    e2 = cyc;
    run_seq(1, 0, 0, 0, d);
    chk("t6.done2", 32'(d), 32'd13);
    step();
    e3 = cyc;
    run_seq(1, 0, 0, 0, d);
    chk("t6.done3", 32'(d), 32'd13);
    chk("t6.period12", 32'(e2 - e1), 32'd14);
    chk("t6.period23", 32'(e3 - e2), 32'd14);
    start_i = 1'b0;
    step();
    chk_quiet("t6.stopped");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
